// File: rtl/if_fetch_if.sv
// Bundle of the fetch unit's external signals: the EX/control inputs, the
// instruction BRAM port and the valid/ready channel towards decode.
interface if_fetch_if #(
    parameter int ADDR_BITS = 10
);
    // Control from the pipeline
    logic                 fetch_en;
    logic                 redirect_valid;
    logic [31:0]          redirect_pc;

    // Instruction BRAM port A
    logic                 imem_ena;
    logic                 imem_wea;
    logic [ADDR_BITS-1:0] imem_addra;
    logic [31:0]          imem_dina;
    logic [31:0]          imem_douta;

    // Fetch-to-decode channel and status
    logic                 if_valid;
    logic                 if_ready;
    logic [31:0]          if_pc;
    logic [31:0]          if_instr;
    logic                 if_misalign;
    logic [31:0]          fetch_count;

    // The fetch unit itself
    modport master (
        input  fetch_en, redirect_valid, redirect_pc, imem_douta, if_ready,
        output imem_ena, imem_wea, imem_addra, imem_dina,
        output if_valid, if_pc, if_instr, if_misalign, fetch_count
    );

    // The surroundings: control, BRAM and decode
    modport slave (
        output fetch_en, redirect_valid, redirect_pc, imem_douta, if_ready,
        input  imem_ena, imem_wea, imem_addra, imem_dina,
        input  if_valid, if_pc, if_instr, if_misalign, fetch_count
    );
endinterface

// File: rtl/if_fetch.sv
// Instruction-fetch front end: reads the instruction BRAM (1-cycle read
// latency) and hands {pc, instr} to decode over a valid/ready handshake.
module if_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          ADDR_BITS = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    if_fetch_if.master   bus
);

    localparam logic [31:0] INSTR_BYTES = 32'd4;

    logic [31:0]          pc_next_q,     pc_next_d;
    logic                 f1_valid_q,    f1_valid_d;
    logic [31:0]          f1_pc_q,       f1_pc_d;
    logic                 misalign_q,    misalign_d;
    logic [31:0]          fetch_count_q, fetch_count_d;

    logic                 adv;
    logic                 accept;
    logic [31:0]          redirect_tgt;
    logic                 ena;
    logic [ADDR_BITS-1:0] addra;

    // The output slot can take a new word when it is empty or being drained.
    assign adv          = !f1_valid_q || bus.if_ready;
    assign redirect_tgt = {bus.redirect_pc[31:2], 2'b00};

    assign bus.if_valid = f1_valid_q && !bus.redirect_valid && rst_n;
    assign accept       = bus.if_valid && bus.if_ready;

    // NOTE: every signal gets a default at the top of always_comb, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        ena           = 1'b0;
        addra         = pc_next_q[ADDR_BITS+1:2];
        pc_next_d     = pc_next_q;
        f1_valid_d    = f1_valid_q;
        f1_pc_d       = f1_pc_q;
        misalign_d    = misalign_q;
        fetch_count_d = fetch_count_q + {31'd0, accept};

        if (!rst_n) begin
            ena = 1'b0;
        end else if (bus.redirect_valid) begin
            // Redirect kills the slot and fetches the target straight away.
            ena        = 1'b1;
            addra      = bus.redirect_pc[ADDR_BITS+1:2];
            f1_valid_d = 1'b1;
            f1_pc_d    = redirect_tgt;
            pc_next_d  = redirect_tgt + INSTR_BYTES;
            if (bus.redirect_pc[1:0] != 2'b00) begin
                misalign_d = 1'b1;
            end
        end else if (adv) begin
            if (bus.fetch_en) begin
                ena        = 1'b1;
                addra      = pc_next_q[ADDR_BITS+1:2];
                f1_valid_d = 1'b1;
                f1_pc_d    = pc_next_q;
                pc_next_d  = pc_next_q + INSTR_BYTES;
            end else begin
                f1_valid_d = 1'b0;
            end
        end
        // Stall: the BRAM is left disabled so douta, and thus if_instr, holds.
    end

    // NOTE: state updates use non-blocking assignments so every register sees
    // the pre-edge value of every other register; reset is sampled on the edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_next_q     <= RESET_PC;
            f1_valid_q    <= 1'b0;
            f1_pc_q       <= 32'd0;
            misalign_q    <= 1'b0;
            fetch_count_q <= 32'd0;
        end else begin
            pc_next_q     <= pc_next_d;
            f1_valid_q    <= f1_valid_d;
            f1_pc_q       <= f1_pc_d;
            misalign_q    <= misalign_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign bus.imem_ena    = ena;
    assign bus.imem_addra  = addra;
    assign bus.imem_wea    = 1'b0;
    assign bus.imem_dina   = 32'd0;

    assign bus.if_pc       = f1_pc_q;
    assign bus.if_instr    = bus.imem_douta;
    assign bus.if_misalign = misalign_q;
    assign bus.fetch_count = fetch_count_q;

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: per-cycle vector table with a behavioural BRAM and a
// scoreboard of expected {pc, instr} deliveries.
module tb_if_fetch;

    localparam int AB = 10;

    logic clk;
    logic rst_n;

    if_fetch_if #(.ADDR_BITS(AB)) bus ();

    if_fetch #(.RESET_PC(32'h0000_0000), .ADDR_BITS(AB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural instruction BRAM with one cycle of read latency
    logic [31:0] mem [1 << AB];

    always @(posedge clk) begin
        if (bus.imem_ena) begin
            bus.imem_douta <= mem[bus.imem_addra];
        end
    end

    function automatic logic [31:0] memword(input logic [31:0] pc);
        logic [AB-1:0] idx;
        idx = pc[AB+1:2];
        return mem[idx];
    endfunction

    typedef struct {
        logic        rst;
        logic        fe;
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic        e_ena;
        logic [AB-1:0] e_addr;
        logic        e_val;
        logic [31:0] e_pc;
        logic [31:0] e_cnt;
        logic        e_mis;
    } vec_t;

    function automatic vec_t v(input logic rst, input logic fe, input logic rv,
                               input logic [31:0] rpc, input logic rdy,
                               input logic e_ena, input logic [AB-1:0] e_addr,
                               input logic e_val, input logic [31:0] e_pc,
                               input logic [31:0] e_cnt, input logic e_mis);
        vec_t r;
        r.rst = rst; r.fe = fe; r.rv = rv; r.rpc = rpc; r.rdy = rdy;
        r.e_ena = e_ena; r.e_addr = e_addr; r.e_val = e_val; r.e_pc = e_pc;
        r.e_cnt = e_cnt; r.e_mis = e_mis;
        return r;
    endfunction

    vec_t        tbl [$];
    logic [63:0] sb  [$];
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic apply_row(input vec_t r, input int idx);
        logic [63:0] e;
        rst_n              = r.rst;
        bus.fetch_en       = r.fe;
        bus.redirect_valid = r.rv;
        bus.redirect_pc    = r.rpc;
        bus.if_ready       = r.rdy;
        if (r.e_val && r.rdy) sb.push_back({r.e_pc, memword(r.e_pc)});
        @(negedge clk);
        check("imem_ena", idx, {31'd0, bus.imem_ena}, {31'd0, r.e_ena});
        if (r.e_ena) check("imem_addra", idx, 32'(bus.imem_addra), 32'(r.e_addr));
        check("if_valid", idx, {31'd0, bus.if_valid}, {31'd0, r.e_val});
        if (r.e_val) begin
            check("if_pc", idx, bus.if_pc, r.e_pc);
            check("if_instr", idx, bus.if_instr, memword(r.e_pc));
        end
        check("fetch_count", idx, bus.fetch_count, r.e_cnt);
        check("if_misalign", idx, {31'd0, bus.if_misalign}, {31'd0, r.e_mis});
        // Scoreboard: every observed handshake must match the oldest expectation
        if (bus.if_valid && bus.if_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected row %0d: got pc %h with nothing expected", idx, bus.if_pc);
            end else begin
                e = sb.pop_front();
                check("sb_pc", idx, bus.if_pc, e[63:32]);
                check("sb_instr", idx, bus.if_instr, e[31:0]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < (1 << AB); i++) begin
            mem[i] = (i < 4) ? 32'h11 * (i + 1) : (32'hC000_0000 | i);
        end

        rst_n              = 1'b0;
        bus.fetch_en       = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'd0;
        bus.if_ready       = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ena", -1, {31'd0, bus.imem_ena}, 32'd0);
        check("rst_valid", -1, {31'd0, bus.if_valid}, 32'd0);
        check("rst_count", -1, bus.fetch_count, 32'd0);
        check("rst_mis", -1, {31'd0, bus.if_misalign}, 32'd0);
        check("rst_wea", -1, {31'd0, bus.imem_wea}, 32'd0);
        check("rst_dina", -1, bus.imem_dina, 32'd0);
        @(posedge clk);
        #1;

        //              rst fe rv rpc           rdy ena addr    val pc            cnt mis
        // Reset release, streaming, then drain with fetch_en=0
        tbl.push_back(v(0, 1, 0, 32'h0,       1,  0, 10'h0,  0, 32'h0,       0,  0));
        tbl.push_back(v(1, 1, 0, 32'h0,       1,  1, 10'h0,  0, 32'h0,       0,  0));
        tbl.push_back(v(1, 1, 0, 32'h0,       1,  1, 10'h1,  1, 32'h0,       0,  0));
        tbl.push_back(v(1, 1, 0, 32'h0,       1,  1, 10'h2,  1, 32'h4,       1,  0));
        tbl.push_back(v(1, 1, 0, 32'h0,       1,  1, 10'h3,  1, 32'h8,       2,  0));
        tbl.push_back(v(1, 1, 0, 32'h0,       1,  1, 10'h4,  1, 32'hC,       3,  0));
        tbl.push_back(v(1, 0, 0, 32'h0,       1,  0, 10'h0,  1, 32'h10,      4,  0));
        tbl.push_back(v(1, 0, 0, 32'h0,       1,  0, 10'h0,  0, 32'h0,       5,  0));
        // Three-cycle stall on pc=8, then no duplicate and no skip
        tbl.push_back(v(0, 1, 0, 32'h0,       1,  0, 10'h0,  0, 32'h0,       5,  0));
        tbl.push_back(v(1, 1, 0, 32'h0,       1,  1, 10'h0,  0, 32'h0,       0,  0));
        tbl.push_back(v(1, 1, 0, 32'h0,       1,  1, 10'h1,  1, 32'h0,       0,  0));
        tbl.push_back(v(1, 1, 0, 32'h0,       1,  1, 10'h2,  1, 32'h4,       1,  0));
        tbl.push_back(v(1, 1, 0, 32'h0,       0,  0, 10'h0,  1, 32'h8,       2,  0));
        tbl.push_back(v(1, 1, 0, 32'h0,       0,  0, 10'h0,  1, 32'h8,       2,  0));
        tbl.push_back(v(1, 1, 0, 32'h0,       0,  0, 10'h0,  1, 32'h8,       2,  0));
        tbl.push_back(v(1, 1, 0, 32'h0,       1,  1, 10'h3,  1, 32'h8,       2,  0));
        tbl.push_back(v(1, 1, 0, 32'h0,       1,  1, 10'h4,  1, 32'hC,       3,  0));
        // Redirects: plain, during stall, misaligned, wrap, back-to-back, over fetch_en=0
        tbl.push_back(v(0, 1, 0, 32'h0,       1,  0, 10'h0,  0, 32'h0,       4,  0));
        tbl.push_back(v(1, 1, 0, 32'h0,       1,  1, 10'h0,  0, 32'h0,       0,  0));
        tbl.push_back(v(1, 1, 0, 32'h0,       1,  1, 10'h1,  1, 32'h0,       0,  0));
        tbl.push_back(v(1, 1, 1, 32'h40,      1,  1, 10'h10, 0, 32'h0,       1,  0));
        tbl.push_back(v(1, 1, 0, 32'h0,       1,  1, 10'h11, 1, 32'h40,      1,  0));
        tbl.push_back(v(1, 1, 0, 32'h0,       1,  1, 10'h12, 1, 32'h44,      2,  0));
        tbl.push_back(v(1, 1, 0, 32'h0,       0,  0, 10'h0,  1, 32'h48,      3,  0));
        tbl.push_back(v(1, 1, 1, 32'h20,      0,  1, 10'h8,  0, 32'h0,       3,  0));
        tbl.push_back(v(1, 1, 0, 32'h0,       1,  1, 10'h9,  1, 32'h20,      3,  0));
        tbl.push_back(v(1, 1, 1, 32'h102,     1,  1, 10'h40, 0, 32'h0,       4,  0));
        tbl.push_back(v(1, 1, 0, 32'h0,       1,  1, 10'h41, 1, 32'h100,     4,  1));
        tbl.push_back(v(1, 1, 1, 32'h1000,    1,  1, 10'h0,  0, 32'h0,       5,  1));
        tbl.push_back(v(1, 1, 0, 32'h0,       1,  1, 10'h1,  1, 32'h1000,    5,  1));
        tbl.push_back(v(1, 1, 1, 32'h80,      1,  1, 10'h20, 0, 32'h0,       6,  1));
        tbl.push_back(v(1, 1, 1, 32'h90,      1,  1, 10'h24, 0, 32'h0,       6,  1));
        tbl.push_back(v(1, 1, 0, 32'h0,       1,  1, 10'h25, 1, 32'h90,      6,  1));
        tbl.push_back(v(1, 0, 0, 32'h0,       1,  0, 10'h0,  1, 32'h94,      7,  1));
        tbl.push_back(v(1, 0, 0, 32'h0,       1,  0, 10'h0,  0, 32'h0,       8,  1));
        tbl.push_back(v(1, 0, 1, 32'h200,     1,  1, 10'h80, 0, 32'h0,       8,  1));
        tbl.push_back(v(1, 0, 0, 32'h0,       1,  0, 10'h0,  1, 32'h200,     8,  1));
        tbl.push_back(v(1, 1, 0, 32'h0,       1,  1, 10'h81, 0, 32'h0,       9,  1));
        tbl.push_back(v(1, 1, 0, 32'h0,       1,  1, 10'h82, 1, 32'h204,     9,  1));
        // Drain after pc=8, resume, reset mid-stall and mid-redirect
        tbl.push_back(v(0, 1, 0, 32'h0,       1,  0, 10'h0,  0, 32'h0,       10, 1));
        tbl.push_back(v(1, 1, 0, 32'h0,       1,  1, 10'h0,  0, 32'h0,       0,  0));
        tbl.push_back(v(1, 1, 0, 32'h0,       1,  1, 10'h1,  1, 32'h0,       0,  0));
        tbl.push_back(v(1, 1, 0, 32'h0,       1,  1, 10'h2,  1, 32'h4,       1,  0));
        tbl.push_back(v(1, 0, 0, 32'h0,       1,  0, 10'h0,  1, 32'h8,       2,  0));
        tbl.push_back(v(1, 0, 0, 32'h0,       1,  0, 10'h0,  0, 32'h0,       3,  0));
        tbl.push_back(v(1, 1, 0, 32'h0,       0,  1, 10'h3,  0, 32'h0,       3,  0));
        tbl.push_back(v(1, 1, 0, 32'h0,       0,  0, 10'h0,  1, 32'hC,       3,  0));
        tbl.push_back(v(0, 1, 0, 32'h0,       0,  0, 10'h0,  0, 32'h0,       3,  0));
        tbl.push_back(v(1, 1, 0, 32'h0,       1,  1, 10'h0,  0, 32'h0,       0,  0));
        tbl.push_back(v(1, 1, 0, 32'h0,       1,  1, 10'h1,  1, 32'h0,       0,  0));
        tbl.push_back(v(0, 1, 1, 32'h40,      1,  0, 10'h0,  0, 32'h0,       1,  0));
        tbl.push_back(v(1, 0, 0, 32'h0,       1,  0, 10'h0,  0, 32'h0,       0,  0));

        for (int i = 0; i < tbl.size(); i++) begin
            apply_row(tbl[i], i);
        end

        check("sb_leftover", tbl.size(), sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch front end of the 5-stage core; the reader side of the instruction BRAM.
- Drives the BRAM port (ena/wea/addra/dina) and absorbs its 1-cycle synchronous read latency.
- Presents {pc, instr} to decode over a valid/ready handshake.
- Supports decode back-pressure, branch/jump redirects from EX, and a fetch enable.

Parameters:
- RESET_PC, 32'h0000_0000, byte address fetched first after reset.
- ADDR_BITS, 10, BRAM word-address width; addra = pc[ADDR_BITS+1:2].

Ports:
- clk  in  1  core clock; BRAM shares it.
- rst_n  in  1  synchronous active-low reset.
- fetch_en  in  1  1 = issue new fetches; 0 = stop issuing, drain the in-flight word.
- redirect_valid  in  1  EX requests a PC change this cycle.
- redirect_pc  in  32  redirect target byte address.
- imem_ena  out  1  BRAM enable.
- imem_wea  out  1  BRAM write enable; constant 0.
- imem_addra  out  ADDR_BITS  BRAM word address.
- imem_dina  out  32  constant 0.
- imem_douta  in  32  BRAM read data, valid 1 cycle after an enabled read.
- if_valid  out  1  {if_pc, if_instr} valid to decode.
- if_ready  in  1  decode accepts this cycle.
- if_pc  out  32  byte PC of if_instr.
- if_instr  out  32  fetched instruction (= imem_douta).
- if_misalign  out  1  sticky; set when redirect_pc[1:0] != 0.
- fetch_count  out  32  number of accepted instructions.

Behaviour:
- Regs: pc_next[31:0], f1_valid, f1_pc[31:0], if_misalign, fetch_count.
- Reset (rst_n=0 at posedge):
  - pc_next=RESET_PC, f1_valid=0, f1_pc=0, if_misalign=0, fetch_count=0.
  - While rst_n=0, imem_ena=0 and if_valid=0.
- adv = !f1_valid || if_ready (output slot empty or being consumed).
- Outputs:
  - if_valid = f1_valid && !redirect_valid && rst_n.
  - if_pc = f1_pc.
  - if_instr = imem_douta.
- Normal issue (rst_n=1, no redirect, fetch_en=1, adv=1):
  - imem_ena=1, imem_addra=pc_next[ADDR_BITS+1:2].
  - Next edge: f1_valid<=1, f1_pc<=pc_next, pc_next<=pc_next+4 (32-bit wrap).
- Stall (f1_valid=1, if_ready=0, no redirect):
  - imem_ena=0; BRAM holds douta, so if_instr and if_pc stay stable.
  - All regs hold. No combinational path from if_ready to data.
- Drain (fetch_en=0, adv=1, no redirect):
  - imem_ena=0, f1_valid<=0, pc_next holds.
  - Re-asserting fetch_en resumes at pc_next.
- Redirect (redirect_valid=1, rst_n=1) has priority over stall and over fetch_en=0:
  - Current f1 word is killed (if_valid=0 this cycle).
  - imem_ena=1, imem_addra=redirect_pc[ADDR_BITS+1:2], where tgt = {redirect_pc[31:2],2'b00}.
  - Next edge: f1_valid<=1, f1_pc<=tgt, pc_next<=tgt+4.
  - Penalty is exactly 1 bubble. If redirect_pc[1:0] != 0, if_misalign<=1 (sticky until reset).
- Back-to-back redirects: each cycle's redirect wins; only the last target's word emerges.
- Address wrap: PC bits above ADDR_BITS+1 are ignored for addra. pc 0x1000 reads word 0, but if_pc reports the full 0x1000.
- fetch_count increments on if_valid && if_ready; wraps at 2^32.
- Reset asserted mid-stall or mid-redirect: the next edge applies reset values. The in-flight word is discarded, never presented.
- Throughput: 1 instr/cycle with if_ready=1.
- Latency: first if_valid comes 1 cycle after the first cycle with rst_n=1 and fetch_en=1.

Test Plan:
- Reset release, RESET_PC=0, BRAM words 0..3 = 0x11,0x22,0x33,0x44, fetch_en=1, if_ready=1 -> addra 0,1,2,3 on consecutive cycles. if_valid rises 1 cycle after release. (pc,instr) = (0,0x11),(4,0x22),(8,0x33),(C,0x44). fetch_count=4.
- Stall: if_ready=0 for 3 cycles while presenting pc=8 -> imem_ena=0 throughout. if_pc=8 and if_instr=0x33 stable. After release, pc=C follows with no duplicate and no skip.
- Redirect with redirect_pc=0x40 while pc=4 is presented -> pc=4 is not accepted (if_valid=0) and addra=0x10 that cycle. Next cycle (0x40, mem[16]), then 0x44.
- Redirect during stall (if_ready=0, redirect_pc=0x20) -> stalled word dropped, next word pc=0x20, fetch_count unchanged by the dropped word.
- Misaligned redirect 0x102 -> if_pc=0x100, if_misalign=1 and stays 1. Wrap check: redirect 0x1000 -> addra=0, if_pc=0x1000.
- fetch_en=0 after pc=8 is issued -> pc=8 delivered, then if_valid=0 and imem_ena=0. rst_n pulsed low mid-stall -> if_valid=0 next cycle, restart at RESET_PC, fetch_count=0.
